nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
// - Multi-cycle WIDTH-bit add/subtract engine built around one shared 4-bit carry-lookahead slice.
// - Processes one nibble per clock, LSB nibble first, with a registered ripple carry between nibbles.
// - Sits beside the ALU datapath as a low-area wide adder; start/busy/done handshake toward the ALU sequencer.
// PARAMETERS
// - WIDTH  16  operand/result width in bits; must be a multiple of 4 and >= 8
// - NIB    WIDTH/4 (derived, localparam)  number of nibble iterations
// PORTS
// - clk       in   1      single clock, rising edge
// - rst       in   1      asynchronous, active-high reset
// - start     in   1      request; sampled only in IDLE or DONE
// - sub       in   1      0 = a+b+cin, 1 = a-b (b inverted, carry-in forced 1, cin ignored)
// - cin       in   1      carry-in for add mode
// - a         in   WIDTH  operand A, captured on accepted start
// - b         in   WIDTH  operand B, captured on accepted start
// - busy      out  1      high while state == RUN
// - done      out  1      one-cycle pulse, high while state == DONE
// - sum       out  WIDTH  registered result
// - cout      out  1      carry out of MSB (sub mode: 1 = no borrow)
// - overflow  out  1      signed overflow = carry into MSB xor carry out of MSB
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, cnt=0, carry reg=0, operand regs=0, busy=0, done=0, sum=0, cout=0, overflow=0.
// - FSM: IDLE -(start)-> RUN; RUN -(cnt==NIB-1)-> DONE; DONE -(start)-> RUN, else -> IDLE.
// - Accepting edge (start in IDLE/DONE): load a, b^{WIDTH{sub}}, carry = sub ? 1 : cin; cnt=0.
// - RUN, each edge: slice consumes low nibble of A/B regs plus carry reg; sum nibble shifted into top of
//   partial-sum shift reg; A/B regs shift right by 4; carry reg <= slice C4; cnt++.
// - Latency: done asserted exactly NIB cycles after the accepting edge (WIDTH=16: 4 cycles); back-to-back
//   start during DONE gives one result every NIB+1 cycles.
// - Result regs (sum, cout, overflow) update only on the RUN->DONE edge; they hold the previous result
//   throughout RUN and IDLE until the next completion.
// - overflow taken from the final nibble: slice C3 (carry into bit 3) xor slice C4.
// - start while busy (RUN) is ignored; no queueing; operands sampled only at acceptance (may change later).
// - sub and cin are sampled only at acceptance.
// - Arithmetic is modulo 2^WIDTH; no saturation.
// - Reset mid-RUN aborts: no done pulse, result regs cleared to 0.
// STRUCTURE
// - Shared package: FSM state enum {IDLE, RUN, DONE} (2-bit), nibble width constant 4, cnt width $clog2(NIB).
// - One sub-module: cla4_slice (inputs a[3:0], b[3:0], c0; outputs s[3:0], c3, c4), purely combinational,
//   built from per-bit P=a^b, G=a&b and a 4-bit lookahead carry network; s[i] = P[i] ^ C[i].
// - Top: FSM, counter, operand shift regs, carry reg, partial-sum shift reg, result regs.
// TESTING (WIDTH=16)
// - add 0x1234+0x4321, cin=0 -> done 4 cycles after accept; sum=0x5555, cout=0, overflow=0; busy high 4 cycles.
// - add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0 (carry ripples through all nibbles).
// - add 0x7FFF+0x0000, cin=1 -> sum=0x8000, cout=0, overflow=1.
// - sub 0x0005-0x0007 -> sum=0xFFFE, cout=0 (borrow), overflow=0; sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, overflow=1.
// - start pulsed mid-RUN with other operands -> ignored, first result unchanged; start held during DONE
//   -> second op accepted, results every 5 cycles.
// - rst asserted at cycle 2 of RUN -> all outputs 0 immediately (async), no done pulse; next start works normally.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl_pkg
// Shared definitions for the nibble-serial add/subtract engine:
//   - state_t   : controller states (IDLE, RUN, DONE), 2-bit encoding
//   - NIBBLE_W  : width of one processing slice (4 bits)
//   - cnt_width : width of the nibble counter for a given nibble count
// ---------------------------------------------------------------------------
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..nib-1; keep at least one bit for degenerate sizes.
    function automatic int cnt_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla4_slice.sv
// ---------------------------------------------------------------------------
// cla4_slice
// Purely combinational 4-bit carry-lookahead adder slice.
// Ports:
//   a, b  in  [3:0]  operand nibbles
//   c0    in  1      carry into bit 0
//   s     out [3:0]  sum nibble
//   c3    out 1      carry into bit 3 (used for signed overflow detection)
//   c4    out 1      carry out of bit 3
// ---------------------------------------------------------------------------
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    // Every carry is expanded directly from generate/propagate terms so no
    // carry depends on another carry: a flat two-level lookahead network.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
        s    = p ^ c[3:0];
        c3   = c[3];
        c4   = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Multi-cycle WIDTH-bit add/subtract engine that reuses one 4-bit CLA slice,
// one nibble per clock, LSB nibble first, with a registered carry between
// nibbles. start/busy/done handshake toward the ALU sequencer.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   start      request, honoured only in IDLE or DONE
//   sub        0: a+b+cin, 1: a-b (cin ignored)
//   cin        carry-in for add mode
//   a, b       operands, captured on the accepting edge
//   busy       high while computing
//   done       one-cycle completion pulse
//   sum        registered result
//   cout       carry out of MSB (subtract: 1 = no borrow)
//   overflow   signed overflow of the last completed operation
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = cnt_width(NIB);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_c3;
    logic                slice_c4;
    logic [WIDTH-1:0]    psum_shift;

    cla4_slice u_slice (
        .a  (a_q[NIBBLE_W-1:0]),
        .b  (b_q[NIBBLE_W-1:0]),
        .c0 (carry_q),
        .s  (slice_s),
        .c3 (slice_c3),
        .c4 (slice_c4)
    );

    // Next-state logic. Subtraction is folded into the load: B is inverted
    // and the initial carry forced to 1, so RUN only ever adds. Result
    // registers move only on the final nibble, so they hold the previous
    // result throughout a new operation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        psum_d     = psum_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        psum_shift = {slice_s, psum_q[WIDTH-1:NIBBLE_W]};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = {{NIBBLE_W{1'b0}}, a_q[WIDTH-1:NIBBLE_W]};
                b_d     = {{NIBBLE_W{1'b0}}, b_q[WIDTH-1:NIBBLE_W]};
                carry_d = slice_c4;
                psum_d  = psum_shift;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    sum_d   = psum_shift;
                    cout_d  = slice_c4;
                    ovf_d   = slice_c3 ^ slice_c4;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered copies of the next state.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Directed and random add/subtract operations on the 16-bit nibble-serial
// adder, compared against an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;
    localparam int MAX_WAIT = 20;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int passCount;
    int totalCount;

    logic [WIDTH-1:0] prevSum;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain unsigned/signed integer arithmetic.
    // Returns {overflow, cout, sum}.
    function automatic logic [WIDTH+1:0] refModel(input logic [WIDTH-1:0] opA,
                                                  input logic [WIDTH-1:0] opB,
                                                  input logic opSub,
                                                  input logic opCin);
        int ua, ub, sa, sb, ures, sres;
        logic c, v;
        logic [WIDTH-1:0] r;
        ua = int'(opA);
        ub = int'(opB);
        sa = int'($signed(opA));
        sb = int'($signed(opB));
        if (opSub) begin
            ures = ua - ub;
            sres = sa - sb;
            c    = (ua >= ub);
        end else begin
            ures = ua + ub + int'(opCin);
            sres = sa + sb + int'(opCin);
            c    = (ures > 65535);
        end
        v = (sres > 32767) || (sres < -32768);
        r = ures[WIDTH-1:0];
        return {v, c, r};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Drive one operation and leave start asserted so the next posedge accepts it.
    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                 input logic opSub, input logic opCin);
        a     = opA;
        b     = opB;
        sub   = opSub;
        cin   = opCin;
        start = 1'b1;
    endtask

    // Wait (bounded) for done after an accepting edge; returns edges seen and busy samples.
    task automatic waitDone(output int edges, output int busyCount);
        edges = 0;
        busyCount = 0;
        while (!done && edges < MAX_WAIT) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busyCount++;
        end
    endtask

    // Full single operation: accept, scramble inputs, check timing and result.
    task automatic runOp(input string tag, input logic [WIDTH-1:0] opA,
                         input logic [WIDTH-1:0] opB, input logic opSub, input logic opCin);
        logic [WIDTH+1:0] exp;
        int edges, busyCount;
        exp = refModel(opA, opB, opSub, opCin);
        applyStimulus(opA, opB, opSub, opCin);
        @(posedge clk);
        #1;
        start = 1'b0;
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        sub = 1'($urandom);
        cin = 1'($urandom);
        checkOutput({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        checkOutput({tag, " sum_held_in_run"}, 32'(sum), 32'(prevSum));
        waitDone(edges, busyCount);
        busyCount++;
        checkOutput({tag, " latency"}, 32'(edges), 32'(NIB));
        checkOutput({tag, " busy_cycles"}, 32'(busyCount), 32'(NIB));
        checkOutput({tag, " sum"}, 32'(sum), 32'(exp[WIDTH-1:0]));
        checkOutput({tag, " cout"}, 32'(cout), 32'(exp[WIDTH]));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(exp[WIDTH+1]));
        @(posedge clk);
        #1;
        checkOutput({tag, " done_pulse_width"}, 32'(done), 32'd0);
        prevSum = exp[WIDTH-1:0];
    endtask

    initial begin
        int edges, busyCount;
        logic [WIDTH+1:0] exp1, exp2;
        logic doneSeen;

        passCount  = 0;
        totalCount = 0;
        prevSum    = '0;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset sum", 32'(sum), 32'd0);
        checkOutput("reset cout", 32'(cout), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed corner cases.
        runOp("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0);
        runOp("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        runOp("add_cin_ovf", 16'h7FFF, 16'h0000, 1'b0, 1'b1);
        runOp("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0);
        runOp("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1);

        // start pulsed mid-RUN with different operands must be ignored.
        exp1 = refModel(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(16'hAAAA, 16'h5555, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(edges, busyCount);
        checkOutput("ignore_midrun latency", 32'(edges + 2), 32'(NIB));
        checkOutput("ignore_midrun sum", 32'(sum), 32'(exp1[WIDTH-1:0]));
        checkOutput("ignore_midrun cout", 32'(cout), 32'(exp1[WIDTH]));
        @(posedge clk);
        #1;
        checkOutput("ignore_midrun idle", 32'(busy | done), 32'd0);

        // start held through DONE: second operation accepted back-to-back.
        exp1 = refModel(16'h1111, 16'h2222, 1'b0, 1'b1);
        exp2 = refModel(16'h9000, 16'h1000, 1'b1, 1'b0);
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(16'h9000, 16'h1000, 1'b1, 1'b0);
        waitDone(edges, busyCount);
        checkOutput("b2b first latency", 32'(edges), 32'(NIB));
        checkOutput("b2b first sum", 32'(sum), 32'(exp1[WIDTH-1:0]));
        waitDoneAfterDone(edges);
        start = 1'b0;
        checkOutput("b2b period", 32'(edges), 32'(NIB + 1));
        checkOutput("b2b second sum", 32'(sum), 32'(exp2[WIDTH-1:0]));
        checkOutput("b2b second cout", 32'(cout), 32'(exp2[WIDTH]));
        checkOutput("b2b second overflow", 32'(overflow), 32'(exp2[WIDTH+1]));
        prevSum = exp2[WIDTH-1:0];
        @(posedge clk);
        #1;

        // Asynchronous reset during RUN aborts the operation.
        applyStimulus(16'h4444, 16'h3333, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort sum", 32'(sum), 32'd0);
        checkOutput("abort cout", 32'(cout), 32'd0);
        checkOutput("abort overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        doneSeen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) doneSeen = 1'b1;
        end
        checkOutput("abort no_done", 32'(doneSeen), 32'd0);
        prevSum = '0;
        runOp("after_abort", 16'h1234, 16'h4321, 1'b0, 1'b0);

        // Random operations.
        for (int i = 0; i < 10; i++) begin
            runOp($sformatf("rand%0d", i), WIDTH'($urandom), WIDTH'($urandom),
                  1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

    // From a done sample, count edges until the next done pulse (bounded).
    task automatic waitDoneAfterDone(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!done && edges < MAX_WAIT);
    endtask

endmodule
